// File: rtl/c17_bist_pkg.sv
// rtl/c17_bist_pkg.sv - shared types and widths for the c17 BIST block
package c17_bist_pkg;

    localparam int C17_IN_W  = 5;
    localparam int C17_OUT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/c17_bist_core.sv
// rtl/c17_bist_core.sv - one combinational ISCAS c17 slice
// in_vec = {gat7,gat6,gat3,gat2,gat1}, out_vec = {gat23,gat22}
module c17_core
    import c17_bist_pkg::*;
(
    input  logic [C17_IN_W-1:0]  in_vec,
    output logic [C17_OUT_W-1:0] out_vec
);

    logic g1, g2, g3, g6, g7;
    logic g10, g11, g16, g19, g22, g23;

    assign {g7, g6, g3, g2, g1} = in_vec;

    assign g10 = ~(g1 & g3);
    assign g11 = ~(g3 & g6);
    assign g16 = ~(g2 & g11);
    assign g19 = ~(g11 & g7);
    assign g22 = ~(g10 & g16);
    assign g23 = ~(g16 & g19);

    assign out_vec = {g23, g22};

endmodule

// File: rtl/c17_bist.sv
// rtl/c17_bist.sv - NUM_CH parallel c17 slices with LFSR/MISR self-test
// Registered datapath: in_reg -> slices -> out_reg, two cycles of latency.
module c17_bist
    import c17_bist_pkg::*;
#(
    parameter int                  NUM_CH    = 4,
    parameter int                  PATTERNS  = 1024,
    parameter logic [5*NUM_CH-1:0] SEED      = (5*NUM_CH)'(40'h00000_00001),
    parameter logic [5*NUM_CH-1:0] LFSR_POLY = (5*NUM_CH)'(40'h80_0000_0015),
    parameter logic [2*NUM_CH-1:0] MISR_POLY = (2*NUM_CH)'(8'h8E),
    parameter logic [2*NUM_CH-1:0] GOLDEN    = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bist_mode,
    input  logic                bist_start,
    input  logic [5*NUM_CH-1:0] func_in,
    output logic [2*NUM_CH-1:0] func_out,
    output logic                bist_busy,
    output logic                bist_done,
    output logic                bist_pass,
    output logic [2*NUM_CH-1:0] signature
);

    localparam int          LW   = C17_IN_W * NUM_CH;
    localparam int          MW   = C17_OUT_W * NUM_CH;
    localparam logic [15:0] LAST = 16'(PATTERNS - 1);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("c17_bist: NUM_CH must be in 1..8");
    end
    if (PATTERNS < 2 || PATTERNS > 65535) begin : g_bad_patterns
        $error("c17_bist: PATTERNS must be in 2..65535");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("c17_bist: SEED must be nonzero");
    end

    bist_state_t    state, state_nxt;
    logic           start_run;
    logic           abort;
    logic           drain_cnt;
    logic [15:0]    cnt;
    logic [LW-1:0]  lfsr, lfsr_nxt;
    logic [MW-1:0]  misr, misr_nxt;
    logic [LW-1:0]  in_reg;
    logic [MW-1:0]  out_reg;
    logic [MW-1:0]  slice_out;
    logic           v1, v2;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        c17_core u_core (
            .in_vec  (in_reg[C17_IN_W*c +: C17_IN_W]),
            .out_vec (slice_out[C17_OUT_W*c +: C17_OUT_W])
        );
    end

    assign lfsr_nxt = {lfsr[LW-2:0], ^(lfsr & LFSR_POLY)};
    assign misr_nxt = {misr[MW-2:0], ^(misr & MISR_POLY)} ^ out_reg;

    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bist_start && bist_mode) begin
                    state_nxt = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bist_mode) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end else if (cnt == LAST) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bist_mode) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end else if (drain_cnt) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bist_mode) begin
                    state_nxt = ST_IDLE;
                end else if (bist_start) begin
                    state_nxt = ST_RUN;
                    start_run = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // v1/v2 track a pattern through in_reg and out_reg so the MISR sees
    // exactly the PATTERNS responses, including the two drained in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED;
            misr      <= '0;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            in_reg    <= '0;
            out_reg   <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            in_reg    <= (state == ST_RUN) ? lfsr : func_in;
            out_reg   <= slice_out;
            v1        <= (state == ST_RUN) && !abort;
            v2        <= v1 && !abort;
            drain_cnt <= (state == ST_DRAIN) && bist_mode && !drain_cnt;
            if (start_run) begin
                lfsr <= SEED;
                cnt  <= '0;
                misr <= '0;
            end else begin
                if (state == ST_RUN) begin
                    lfsr <= lfsr_nxt;
                    cnt  <= cnt + 16'd1;
                end
                if (v2 && !abort) begin
                    misr <= misr_nxt;
                end
            end
        end
    end

    assign func_out  = out_reg;
    assign signature = misr;
    assign bist_busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign bist_done = (state == ST_DONE);
    assign bist_pass = (state == ST_DONE) && (misr == GOLDEN);

endmodule

// File: tb/tb_c17_bist.sv
// tb/tb_c17_bist.sv - self-checking bench for c17_bist
module tb_c17_bist;

    localparam int          NCH    = 4;
    localparam int          NPAT   = 8;
    localparam logic [19:0] SEED_V = 20'h00001;
    localparam logic [19:0] LFSR_P = 20'h00015;
    localparam logic [7:0]  MISR_P = 8'h8E;

    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic g1, g2, g3, g6, g7;
        {g7, g6, g3, g2, g1} = v;
        return {~(g3 & g6) & (g2 | g7), (g1 & g3) | (g2 & ~(g3 & g6))};
    endfunction

    function automatic logic [7:0] slices_ref(input logic [19:0] v, input bit fault);
        logic [7:0] o;
        for (int c = 0; c < NCH; c++) o[2*c +: 2] = c17_ref(v[5*c +: 5]);
        if (fault) o[0] = 1'b0;
        return o;
    endfunction

    function automatic logic [7:0] model_sig(input bit fault);
        logic [19:0] lf;
        logic [7:0]  m;
        lf = SEED_V;
        m  = 8'h00;
        for (int p = 0; p < NPAT; p++) begin
            m  = {m[6:0], ^(m & MISR_P)} ^ slices_ref(lf, fault);
            lf = {lf[18:0], ^(lf & LFSR_P)};
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = model_sig(1'b0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bist_mode = 1'b0, bist_start = 1'b0;
    logic [19:0] func_in = '0;
    logic [7:0]  func_out, signature;
    logic        bist_busy, bist_done, bist_pass;

    logic        mode_s = 1'b0, start_s = 1'b0;
    logic [4:0]  func_in_s = '0;
    logic [1:0]  func_out_s, signature_s;
    logic        busy_s, done_s, pass_s;

    int errors = 0;
    int checks = 0;

    logic [7:0] sig_q[$];
    logic [7:0] out_q[$];
    logic [1:0] out_q_s[$];

    always #5 clk = ~clk;

    c17_bist #(.NUM_CH(NCH), .PATTERNS(NPAT), .SEED(SEED_V), .LFSR_POLY(LFSR_P),
               .MISR_POLY(MISR_P), .GOLDEN(GOLD)) dut (
        .clk(clk), .rst_n(rst_n), .bist_mode(bist_mode), .bist_start(bist_start),
        .func_in(func_in), .func_out(func_out), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_pass(bist_pass), .signature(signature));

    c17_bist #(.NUM_CH(1), .PATTERNS(NPAT), .SEED(5'h01), .LFSR_POLY(5'h15),
               .MISR_POLY(2'h2), .GOLDEN(2'h0)) dut_s (
        .clk(clk), .rst_n(rst_n), .bist_mode(mode_s), .bist_start(start_s),
        .func_in(func_in_s), .func_out(func_out_s), .bist_busy(busy_s),
        .bist_done(done_s), .bist_pass(pass_s), .signature(signature_s));

    task automatic pulse_start;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
    endtask

    // Starts counting on the first RUN negedge; re-pulses start at busy cycle `inject`.
    task automatic run_bist(input int inject, output int busy_cycles, output bit done_seen);
        busy_cycles = 0;
        done_seen   = 1'b0;
        for (int i = 0; i < 100 && !done_seen; i++) begin
            if (bist_done) begin
                done_seen = 1'b1;
            end else begin
                if (bist_busy) begin
                    busy_cycles++;
                    bist_start = (busy_cycles == inject);
                end
                @(negedge clk);
            end
        end
        bist_start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (func_out !== 8'h00) begin errors++; $display("FAIL reset_func_out: got %h expected 00", func_out); end
        checks++; if (signature !== 8'h00) begin errors++; $display("FAIL reset_signature: got %h expected 00", signature); end
        checks++; if ({bist_busy, bist_done, bist_pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bist_busy, bist_done, bist_pass}); end
        checks++; if (func_out_s !== 2'b00) begin errors++; $display("FAIL reset_func_out_s: got %b expected 00", func_out_s); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_known_vectors;
        logic [4:0] vec[5] = '{5'b11111, 5'b00000, 5'b10101, 5'b01010, 5'b00111};
        logic [1:0] exp_s;
        out_q_s.delete();
        for (int i = 0; i < 7; i++) begin
            if (i >= 2) begin
                exp_s = out_q_s.pop_front();
                checks++; if (func_out_s !== exp_s) begin errors++; $display("FAIL known_vec_%0d: got %b expected %b", i - 2, func_out_s, exp_s); end
            end
            if (i < 5) begin
                func_in_s = vec[i];
                out_q_s.push_back(c17_ref(vec[i]));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] v;
        logic [7:0]  exp_o;
        out_q.delete();
        for (int i = 0; i < 26; i++) begin
            if (i >= 2) begin
                exp_o = out_q.pop_front();
                checks++; if (func_out !== exp_o) begin errors++; $display("FAIL b2b_vec_%0d: got %h expected %h", i - 2, func_out, exp_o); end
            end
            if (i < 24) begin
                v = 20'($urandom);
                func_in = v;
                out_q.push_back(slices_ref(v, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int inject, input logic [7:0] exp_sig);
        int         busy_cycles;
        bit         done_seen;
        logic [7:0] exp_s;
        sig_q.push_back(exp_sig);
        pulse_start();
        run_bist(inject, busy_cycles, done_seen);
        exp_s = sig_q.pop_front();
        checks++; if (!done_seen) begin errors++; $display("FAIL %s_done: got no done within bound expected done", name); end
        checks++; if (busy_cycles != 10) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 10", name, busy_cycles); end
        checks++; if (signature !== exp_s) begin errors++; $display("FAIL %s_signature: got %h expected %h", name, signature, exp_s); end
        checks++; if (bist_pass !== (exp_s == GOLD)) begin errors++; $display("FAIL %s_pass: got %b expected %b", name, bist_pass, exp_s == GOLD); end
    endtask

    task automatic test_bist_run;
        bist_mode = 1'b1;
        check_run("bist_run", 0, GOLD);
        repeat (3) @(negedge clk);
        checks++; if (signature !== GOLD || bist_done !== 1'b1) begin errors++; $display("FAIL done_hold: got sig %h done %b expected sig %h done 1", signature, bist_done, GOLD); end
        check_run("bist_rerun", 0, GOLD);
    endtask

    task automatic test_start_ignored;
        check_run("start_while_busy", 4, GOLD);
    endtask

    task automatic test_fault;
        force dut.g_ch[0].u_core.g22 = 1'b0;
        check_run("fault_g22", 0, model_sig(1'b1));
        release dut.g_ch[0].u_core.g22;
        checks++; if (bist_pass !== 1'b0) begin errors++; $display("FAIL fault_pass_low: got %b expected 0", bist_pass); end
    endtask

    task automatic test_abort;
        bit saw_done = 1'b0;
        pulse_start();
        repeat (4) @(negedge clk);
        bist_mode = 1'b0;
        @(negedge clk);
        checks++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b done %b expected 0 0", bist_busy, bist_done); end
        for (int i = 0; i < 15; i++) begin
            if (bist_done) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done: got done asserted expected none"); end
        bist_mode = 1'b1;
        check_run("abort_rerun", 0, GOLD);
    endtask

    task automatic test_mode0_start;
        bit saw_busy = 1'b0;
        bist_mode = 1'b0;
        @(negedge clk);
        checks++; if (bist_done !== 1'b0) begin errors++; $display("FAIL mode0_exit_done: got %b expected 0", bist_done); end
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (bist_busy) saw_busy = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_busy) begin errors++; $display("FAIL mode0_start: got busy expected idle"); end
    endtask

    task automatic test_reset_mid_run;
        bit saw_flag = 1'b0;
        bist_mode = 1'b1;
        pulse_start();
        repeat (3) @(negedge clk);
        checks++; if (bist_busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", bist_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (func_out !== 8'h00 || signature !== 8'h00) begin errors++; $display("FAIL midrun_reset_data: got out %h sig %h expected 00 00", func_out, signature); end
        checks++; if ({bist_busy, bist_done, bist_pass} !== 3'b000) begin errors++; $display("FAIL midrun_reset_flags: got %b expected 000", {bist_busy, bist_done, bist_pass}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bist_done || bist_busy) saw_flag = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_flag) begin errors++; $display("FAIL midrun_after_release: got busy/done expected idle"); end
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_bist_run();
        test_start_ignored();
        test_fault();
        test_abort();
        test_mode0_start();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
